// File: rtl/alu_control_unit_pkg.sv
// Shared definitions for the shift/add multiply, restoring divide ALU sequencer:
// state encoding, op codes, control-word bit positions and iteration limits.
package alu_control_unit_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LD_Q,
        S_LD_M,
        S_EXEC,
        S_CLR_A,
        S_MUL_ADD,
        S_MUL_SHF,
        S_DIV_SHF,
        S_DIV_SUB,
        S_DIV_FIX,
        S_DONE
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam int CTRL_W   = 11;
    localparam int C_LOAD_Q = 0;
    localparam int C_LOAD_M = 1;
    localparam int C_LOAD_A = 2;
    localparam int C_SUB    = 3;
    localparam int C_SHIFT  = 4;
    localparam int C_COUNT  = 5;
    localparam int C_BIT_IN = 6;
    localparam int C_CLR_A  = 7;
    localparam int C_SET_Q0 = 8;

    localparam logic [1:0] OPND_NONE = 2'b00;
    localparam logic [1:0] OPND_Q    = 2'b01;
    localparam logic [1:0] OPND_M    = 2'b10;

    localparam logic [2:0] ITER_LAST = 3'd7;

endpackage

// File: rtl/alu_control_unit.sv
// Sequencer for an 8-bit add/sub/mul/div datapath; drives the c0..c10 control word.
// Optional macro ALU_CTRL_DBZ_EN: divide by zero terminates early with err.
module alu_control_unit
    import alu_control_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic              q0,
    input  logic              a_msb,
    input  logic              m_zero,
    output logic [CTRL_W-1:0] ctrl,
    output logic [1:0]        opnd_sel,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t     state;
    state_t     next;
    logic [2:0] iter_cnt;
    logic [1:0] op_r;
    logic       dbz;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            iter_cnt <= 3'd0;
            op_r     <= OP_ADD;
        end else begin
            state <= next;
            if (state == S_IDLE && start) begin
                op_r <= op;
            end
            // Counter wraps 7->0 exactly on the terminating iteration.
            if (state == S_CLR_A) begin
                iter_cnt <= 3'd0;
            end else if (state == S_MUL_SHF || state == S_DIV_FIX) begin
                iter_cnt <= iter_cnt + 3'd1;
            end
        end
    end

`ifdef ALU_CTRL_DBZ_EN
    logic dbz_r;

    assign dbz = (op_r == OP_DIV) && m_zero;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dbz_r <= 1'b0;
        end else if (state == S_CLR_A) begin
            dbz_r <= dbz;
        end else if (state == S_IDLE) begin
            dbz_r <= 1'b0;
        end
    end

    assign err = (state == S_DONE) && dbz_r;
`else
    logic unused_m_zero;

    assign unused_m_zero = m_zero;
    assign dbz           = 1'b0;
    assign err           = 1'b0;
`endif

    always_comb begin
        next     = state;
        ctrl     = '0;
        opnd_sel = OPND_NONE;
        busy     = (state != S_IDLE);
        done     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) next = S_LD_Q;
            end
            S_LD_Q: begin
                ctrl[C_LOAD_Q] = 1'b1;
                opnd_sel       = OPND_Q;
                next           = S_LD_M;
            end
            S_LD_M: begin
                ctrl[C_LOAD_M] = 1'b1;
                opnd_sel       = OPND_M;
                next           = op_r[1] ? S_CLR_A : S_EXEC;
            end
            S_EXEC: begin
                ctrl[C_SUB] = op_r[0];
                next        = S_DONE;
            end
            S_CLR_A: begin
                ctrl[C_CLR_A] = 1'b1;
                if (dbz)                 next = S_DONE;
                else if (op_r == OP_MUL) next = S_MUL_ADD;
                else                     next = S_DIV_SHF;
            end
            S_MUL_ADD: begin
                ctrl[C_LOAD_A] = q0;
                next           = S_MUL_SHF;
            end
            S_MUL_SHF: begin
                ctrl[C_SHIFT] = 1'b1;
                ctrl[C_COUNT] = 1'b1;
                next          = (iter_cnt == ITER_LAST) ? S_DONE : S_MUL_ADD;
            end
            S_DIV_SHF: begin
                ctrl[C_SHIFT] = 1'b1;
                next          = S_DIV_SUB;
            end
            S_DIV_SUB: begin
                ctrl[C_LOAD_A] = 1'b1;
                ctrl[C_SUB]    = 1'b1;
                next           = S_DIV_FIX;
            end
            S_DIV_FIX: begin
                // Negative partial remainder: add M back; otherwise record a quotient 1.
                ctrl[C_COUNT] = 1'b1;
                if (a_msb) ctrl[C_LOAD_A] = 1'b1;
                else       ctrl[C_SET_Q0] = 1'b1;
                next = (iter_cnt == ITER_LAST) ? S_DONE : S_DIV_SHF;
            end
            S_DONE: begin
                done = 1'b1;
                next = S_IDLE;
            end
            default: begin
                next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_control_unit.sv
// Bench for alu_control_unit: a behavioural 8-bit datapath reacts to ctrl and feeds
// q0/a_msb/m_zero back; expected results are queued at issue and popped at done.
module tb_alu_control_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic        q0, a_msb, m_zero;
    logic [10:0] ctrl;
    logic [1:0]  opnd_sel;
    logic        busy, done, err;

    always #5 clk = ~clk;

    alu_control_unit dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .q0       (q0),
        .a_msb    (a_msb),
        .m_zero   (m_zero),
        .ctrl     (ctrl),
        .opnd_sel (opnd_sel),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    // Datapath model: A, Q, M registers with carry, updated by the ctrl word of the cycle.
    logic [7:0]  ra = 8'h00, rq = 8'h00, rm = 8'h00;
    logic        rc = 1'b0;
    logic [10:0] ctrl_s = 11'h000;
    logic [1:0]  cur_op = 2'b00;
    logic [7:0]  opa = 8'h00, opb = 8'h00;

    assign q0     = rq[0];
    assign a_msb  = ra[7];
    assign m_zero = (rm == 8'h00);

    always @(negedge clk) ctrl_s = ctrl;

    always @(posedge clk) begin
        if (ctrl_s[0]) rq <= opa;
        if (ctrl_s[1]) rm <= opb;
        if (ctrl_s[7]) begin
            ra <= 8'h00;
            rc <= 1'b0;
        end
        if (ctrl_s[2]) begin
            if (ctrl_s[3]) {rc, ra} <= {1'b0, ra} - {1'b0, rm};
            else           {rc, ra} <= {1'b0, ra} + {1'b0, rm};
        end
        if (ctrl_s[4]) begin
            if (cur_op == 2'b10) {rc, ra, rq} <= {ctrl_s[6], rc, ra, rq[7:1]};
            else                 {ra, rq}     <= {ra[6:0], rq, ctrl_s[6]};
        end
        if (ctrl_s[8]) rq[0] <= 1'b1;
    end

    typedef struct {
        logic [15:0] z;
        logic [7:0]  r;
        int          lat;
        logic        e;
    } exp_t;

    exp_t sb[$];
    exp_t ex;

    int n_cmp = 0;
    int n_fail = 0;

    int          lat_o;
    logic [15:0] z_o;
    logic [7:0]  r_o;
    logic        err_o, to_o, exec_c3_o, done_after;
    int          add_n, shf_n, fix_n, opsel_bad, hi_bad;

    function automatic logic [15:0] sx(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

    function automatic int lat_of(input logic [1:0] o);
        if (!o[1]) return 4;
        return o[0] ? 28 : 20;
    endfunction

    // Issue one operation at the current negedge and follow it to done (bounded).
    task automatic run_op(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
        logic [10:0] prev;
        cur_op = o; opa = a; opb = b;
        start = 1'b1; op = o;
        prev = '0; to_o = 1'b1; lat_o = 0; z_o = 'x; r_o = 'x; err_o = 1'bx;
        exec_c3_o = 1'bx;
        add_n = 0; shf_n = 0; fix_n = 0; opsel_bad = 0; hi_bad = 0;
        @(posedge clk);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (ctrl[0]) begin
                if (opnd_sel !== 2'b01) opsel_bad++;
            end else if (ctrl[1]) begin
                if (opnd_sel !== 2'b10) opsel_bad++;
            end else if (opnd_sel !== 2'b00) opsel_bad++;
            if (ctrl[10:9] !== 2'b00) hi_bad++;
            if (o == 2'b10 && ctrl[2] && !ctrl[3]) add_n++;
            if (ctrl[4] && ctrl[5]) shf_n++;
            if (ctrl[5] && !ctrl[4]) fix_n++;
            if (prev[1] && !o[1]) begin
                exec_c3_o = ctrl[3];
                z_o = ctrl[3] ? sx(rq) - sx(rm) : sx(rq) + sx(rm);
            end
            if (done) begin
                lat_o = c;
                err_o = err;
                if (o[1]) begin
                    z_o = o[0] ? {8'h00, rq} : {ra, rq};
                    r_o = ra;
                end
                to_o = 1'b0;
                break;
            end
            prev = ctrl;
        end
        @(negedge clk);
        done_after = done;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
        n_cmp++; if (ctrl !== 11'h000) begin n_fail++; $display("FAIL reset_ctrl: got %h want 000", ctrl); end
        n_cmp++; if (opnd_sel !== 2'b00) begin n_fail++; $display("FAIL reset_opnd_sel: got %b want 00", opnd_sel); end
        rst = 1'b1;
    endtask

    task automatic test_add;
        sb.push_back('{z: 16'd42, r: 8'd0, lat: 4, e: 1'b0});
        run_op(2'b00, 8'd25, 8'd17);
        ex = sb.pop_front();
        n_cmp++; if (to_o !== 1'b0) begin n_fail++; $display("FAIL add_timeout: no done within bound"); end
        n_cmp++; if (lat_o != ex.lat) begin n_fail++; $display("FAIL add_latency: got %0d want %0d", lat_o, ex.lat); end
        n_cmp++; if (z_o !== ex.z) begin n_fail++; $display("FAIL add_z: got %h want %h", z_o, ex.z); end
        n_cmp++; if (exec_c3_o !== 1'b0) begin n_fail++; $display("FAIL add_exec_c3: got %b want 0", exec_c3_o); end
        n_cmp++; if (err_o !== ex.e) begin n_fail++; $display("FAIL add_err: got %b want %b", err_o, ex.e); end
        n_cmp++; if (opsel_bad != 0) begin n_fail++; $display("FAIL add_opnd_sel: %0d bad cycles want 0", opsel_bad); end
        n_cmp++; if (done_after !== 1'b0) begin n_fail++; $display("FAIL add_done_pulse: got %b want 0", done_after); end
    endtask

    task automatic test_sub;
        sb.push_back('{z: 16'hFFFC, r: 8'd0, lat: 4, e: 1'b0});
        run_op(2'b01, 8'd5, 8'd9);
        ex = sb.pop_front();
        n_cmp++; if (lat_o != ex.lat) begin n_fail++; $display("FAIL sub_latency: got %0d want %0d", lat_o, ex.lat); end
        n_cmp++; if (z_o !== ex.z) begin n_fail++; $display("FAIL sub_z: got %h want %h", z_o, ex.z); end
        n_cmp++; if (exec_c3_o !== 1'b1) begin n_fail++; $display("FAIL sub_exec_c3: got %b want 1", exec_c3_o); end
    endtask

    task automatic test_mul;
        sb.push_back('{z: 16'd143, r: 8'd0, lat: 20, e: 1'b0});
        run_op(2'b10, 8'd13, 8'd11);
        ex = sb.pop_front();
        n_cmp++; if (lat_o != ex.lat) begin n_fail++; $display("FAIL mul_latency: got %0d want %0d", lat_o, ex.lat); end
        n_cmp++; if (z_o !== ex.z) begin n_fail++; $display("FAIL mul_z: got %0d want %0d", z_o, ex.z); end
        n_cmp++; if (add_n != 3) begin n_fail++; $display("FAIL mul_add_cycles: got %0d want 3", add_n); end
        n_cmp++; if (shf_n != 8) begin n_fail++; $display("FAIL mul_shift_cycles: got %0d want 8", shf_n); end
        n_cmp++; if (hi_bad != 0) begin n_fail++; $display("FAIL mul_ctrl_hi: %0d cycles with c9/c10 set want 0", hi_bad); end
        n_cmp++; if (opsel_bad != 0) begin n_fail++; $display("FAIL mul_opnd_sel: %0d bad cycles want 0", opsel_bad); end
    endtask

    task automatic test_div;
        sb.push_back('{z: 16'd14, r: 8'd2, lat: 28, e: 1'b0});
        run_op(2'b11, 8'd100, 8'd7);
        ex = sb.pop_front();
        n_cmp++; if (lat_o != ex.lat) begin n_fail++; $display("FAIL div_latency: got %0d want %0d", lat_o, ex.lat); end
        n_cmp++; if (z_o !== ex.z) begin n_fail++; $display("FAIL div_quotient: got %0d want %0d", z_o, ex.z); end
        n_cmp++; if (r_o !== ex.r) begin n_fail++; $display("FAIL div_remainder: got %0d want %0d", r_o, ex.r); end
        n_cmp++; if (fix_n != 8) begin n_fail++; $display("FAIL div_fix_cycles: got %0d want 8", fix_n); end
        n_cmp++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL div_err: got %b want 0", err_o); end
    endtask

    task automatic test_div_zero;
`ifdef ALU_CTRL_DBZ_EN
        sb.push_back('{z: 16'd0, r: 8'd0, lat: 4, e: 1'b1});
`else
        sb.push_back('{z: 16'd0, r: 8'd0, lat: 28, e: 1'b0});
`endif
        run_op(2'b11, 8'd100, 8'd0);
        ex = sb.pop_front();
        n_cmp++; if (lat_o != ex.lat) begin n_fail++; $display("FAIL dbz_latency: got %0d want %0d", lat_o, ex.lat); end
        n_cmp++; if (err_o !== ex.e) begin n_fail++; $display("FAIL dbz_err: got %b want %b", err_o, ex.e); end
        n_cmp++; if (done_after !== 1'b0) begin n_fail++; $display("FAIL dbz_done_pulse: got %b want 0", done_after); end
    endtask

    task automatic test_reset_mid;
        int shf;
        shf = 0;
        cur_op = 2'b10; opa = 8'd13; opb = 8'd11;
        start = 1'b1; op = 2'b10;
        @(posedge clk);
        for (int c = 0; c < 30 && shf < 4; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (ctrl[4] && ctrl[5]) shf++;
        end
        n_cmp++; if (shf != 4) begin n_fail++; $display("FAIL rstmid_reach: got %0d shift cycles want 4", shf); end
        #1 rst = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        n_cmp++; if (ctrl !== 11'h000) begin n_fail++; $display("FAIL rstmid_ctrl: got %h want 000", ctrl); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done: got %b want 0", done); end
        @(negedge clk);
        rst = 1'b1;
        sb.push_back('{z: 16'd143, r: 8'd0, lat: 20, e: 1'b0});
        run_op(2'b10, 8'd13, 8'd11);
        ex = sb.pop_front();
        n_cmp++; if (lat_o != ex.lat) begin n_fail++; $display("FAIL rstmid_mul_latency: got %0d want %0d", lat_o, ex.lat); end
        n_cmp++; if (z_o !== ex.z) begin n_fail++; $display("FAIL rstmid_mul_z: got %0d want %0d", z_o, ex.z); end
    endtask

    task automatic test_back_to_back;
        logic [10:0] prev;
        logic [15:0] z;
        int ndone;
        cur_op = 2'b00; opa = 8'd25; opb = 8'd17;
        sb.push_back('{z: 16'd42, r: 8'd0, lat: 4, e: 1'b0});
        sb.push_back('{z: 16'd42, r: 8'd0, lat: 9, e: 1'b0});
        start = 1'b1; op = 2'b00;
        prev = '0; ndone = 0; z = 'x;
        @(posedge clk);
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (prev[1]) z = ctrl[3] ? sx(rq) - sx(rm) : sx(rq) + sx(rm);
            if (done) begin
                ex = sb.pop_front();
                n_cmp++; if (c != ex.lat) begin n_fail++; $display("FAIL b2b_done_cycle: got %0d want %0d", c, ex.lat); end
                n_cmp++; if (z !== ex.z) begin n_fail++; $display("FAIL b2b_z: got %h want %h", z, ex.z); end
                ndone++;
                if (ndone == 2) begin
                    start = 1'b0;
                    break;
                end
            end
            prev = ctrl;
        end
        start = 1'b0;
        n_cmp++; if (ndone != 2) begin n_fail++; $display("FAIL b2b_count: got %0d done pulses want 2", ndone); end
        sb.delete();
        repeat (2) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_after: busy %b want 0", busy); end
    endtask

    task automatic test_random;
        logic [1:0] o;
        logic [7:0] a, b;
        logic [15:0] ez;
        logic [7:0]  er;
        for (int i = 0; i < 10; i++) begin
            o = 2'($urandom_range(0, 3));
            a = 8'($urandom_range(0, 255));
            b = (o == 2'b11) ? 8'($urandom_range(1, 127)) : 8'($urandom_range(0, 255));
            er = 8'd0;
            case (o)
                2'b00:   ez = sx(a) + sx(b);
                2'b01:   ez = sx(a) - sx(b);
                2'b10:   ez = 16'(a) * 16'(b);
                default: begin ez = 16'(a / b); er = a % b; end
            endcase
            sb.push_back('{z: ez, r: er, lat: lat_of(o), e: 1'b0});
            run_op(o, a, b);
            ex = sb.pop_front();
            n_cmp++; if (lat_o != ex.lat) begin n_fail++; $display("FAIL rand_latency: op %0d got %0d want %0d", o, lat_o, ex.lat); end
            n_cmp++; if (z_o !== ex.z) begin n_fail++; $display("FAIL rand_z: op %0d a %0d b %0d got %h want %h", o, a, b, z_o, ex.z); end
            if (o == 2'b11) begin
                n_cmp++; if (r_o !== ex.r) begin n_fail++; $display("FAIL rand_rem: a %0d b %0d got %0d want %0d", a, b, r_o, ex.r); end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_div();
        test_div_zero();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
